// File: rtl/load_store_unit.sv
// Load/store unit for an RV32I core. It turns byte, half and word accesses
// into whole-word accesses on a single-port word memory. Sub-word stores use
// a read-modify-write sequence. Accesses that are misaligned, use an illegal
// width code or fall outside the decoded range are answered with an error
// and never touch memory.
module load_store_unit #(
  parameter int ADDR_W = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;
  logic [31:0] merged_reg;

  logic        handshake;
  logic        out_of_range;
  logic        req_err;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic [3:0]  lane_sel;
  logic        is_half;

  assign handshake    = req_valid & req_ready;
  assign out_of_range = (req_addr >> ADDR_W) != 32'd0;

  // Classify the incoming request as legal or erroneous
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = (req_addr[1:0] != 2'b00);
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (out_of_range) begin
      req_err = 1'b1;
    end
  end

  // Pick the addressed lane out of the read word and extend it to 32 bits
  always_comb begin
    byte_lane = 8'h00;
    case (addr_reg[1:0])
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_reg)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_data = {24'h000000, byte_lane};
      3'b101:  load_data = {16'h0000, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

  // Sub-word store merge: each byte lane takes store data when addressed,
  // otherwise keeps the byte just read from memory
  assign is_half = funct3_reg[0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      localparam int         OFS  = 8 * (gi % 2);
      assign lane_sel[gi] = is_half ? (addr_reg[1] == LANE[1])
                                    : (addr_reg[1:0] == LANE);
      assign merged_word[8*gi +: 8] = !lane_sel[gi] ? mem_rdata[8*gi +: 8]
                                    : (is_half ? wdata_reg[OFS +: 8] : wdata_reg[7:0]);
    end
  endgenerate

  // Access sequencer: latch request, run memory phase(s), respond once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      funct3_reg <= 3'b000;
      err_reg    <= 1'b0;
      rdata_reg  <= 32'h0;
      merged_reg <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            funct3_reg <= req_funct3;
            err_reg    <= req_err;
            rdata_reg  <= 32'h0;
            if (req_err) begin
              state_reg <= RESP;
            end else if (!req_we) begin
              state_reg <= LOAD;
            end else if (req_funct3[1:0] == 2'b10) begin
              state_reg <= WRITE;
            end else begin
              state_reg <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rdata_reg <= load_data;
          state_reg <= RESP;
        end
        RMW_RD: begin
          merged_reg <= merged_word;
          state_reg  <= WRITE;
        end
        WRITE: begin
          state_reg <= RESP;
        end
        RESP: begin
          rdata_reg <= 32'h0;
          err_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode the state and are forced low while reset is held
  assign req_ready  = rst_n & (state_reg == IDLE);
  assign resp_valid = rst_n & (state_reg == RESP);
  assign resp_err   = resp_valid & err_reg;
  assign resp_rdata = resp_valid ? rdata_reg : 32'h0;
  assign mem_read   = rst_n & ((state_reg == LOAD) | (state_reg == RMW_RD));
  assign mem_write  = rst_n & (state_reg == WRITE);
  assign mem_addr   = (mem_read | mem_write) ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = !mem_write ? 32'h0 : (funct3_reg[1] ? wdata_reg : merged_reg);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a word memory model answers the
// DUT, a reference memory predicts results, and a scoreboard compares each
// response against the expectation queued when the request was driven.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  logic [31:0] dmem    [0:2047];
  logic [31:0] ref_mem [0:2047];

  assign mem_rdata = dmem[mem_addr[12:2]];

  load_store_unit #(.ADDR_W(13)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [63:0] name;
  } exp_t;

  exp_t        exp_q[$];
  int          hs_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          cur_rd   = 0;
  int          cur_wr   = 0;
  int          total_wr = 0;
  bit          hs_now   = 1'b0;
  bit          wr_pend  = 1'b0;
  logic [10:0] wr_idx;
  logic [31:0] wr_data;
  logic [31:0] last_rdata = 32'h0;

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic e;
    e = 1'b0;
    if (a >= 32'h0000_2000) e = 1'b1;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) e = 1'b1;
    if (we && f3[2]) e = 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) e = 1'b1;
    if (f3[1:0] == 2'b01 && a[0]) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] bsh;
    logic [31:0] hsh;
    logic [7:0]  b;
    logic [15:0] h;
    bsh = w >> (8 * off);
    hsh = w >> (16 * off[1]);
    b = bsh[7:0];
    h = hsh[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << (8 * off);
    return (old & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  // One clock: monitor at the falling edge, apply memory write at the rising edge
  task automatic cycle();
    exp_t e;
    int   h;
    int   lat;
    @(negedge clk);
    hs_now = req_valid && req_ready;
    if (!rst_n) begin
      n_checks++;
      if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0 ||
          resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got ready=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h, required all 0",
                 req_ready, resp_valid, resp_err, mem_read, mem_write, resp_rdata, mem_addr, mem_wdata);
      end
      hs_q.delete();
      cur_rd = 0;
      cur_wr = 0;
    end else begin
      if (hs_now) hs_q.push_back(cyc);
      n_checks++;
      if (mem_read && mem_write) begin
        n_fail++;
        $display("FAIL rd_wr_exclusive: got mem_read=%b mem_write=%b, required not both 1", mem_read, mem_write);
      end
      n_checks++;
      if (req_ready && (mem_read || mem_write || resp_valid)) begin
        n_fail++;
        $display("FAIL ready_only_idle: got ready=1 with rd=%b wr=%b rv=%b, required ready=0", mem_read, mem_write, resp_valid);
      end
      if (!resp_valid) begin
        n_checks++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL resp_idle_zero: got rdata=%h err=%b, required 0", resp_rdata, resp_err);
        end
      end
      if (!mem_read && !mem_write) begin
        n_checks++;
        if (mem_addr !== 32'h0) begin
          n_fail++;
          $display("FAIL addr_idle_zero: got mem_addr=%h, required 0", mem_addr);
        end
      end
      if (!mem_write) begin
        n_checks++;
        if (mem_wdata !== 32'h0) begin
          n_fail++;
          $display("FAIL wdata_idle_zero: got mem_wdata=%h, required 0", mem_wdata);
        end
      end
      if (mem_read || mem_write) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_access: got rd=%b wr=%b addr=%h, required no access", mem_read, mem_write, mem_addr);
        end else begin
          if (mem_addr !== exp_q[0].waddr) begin
            n_fail++;
            $display("FAIL mem_addr: got %h, required %h", mem_addr, exp_q[0].waddr);
          end
          if (mem_write) begin
            n_checks++;
            if (mem_wdata !== exp_q[0].wdata) begin
              n_fail++;
              $display("FAIL mem_wdata: got %h, required %h", mem_wdata, exp_q[0].wdata);
            end
          end
        end
        if (mem_read) cur_rd++;
        if (mem_write) begin
          cur_wr++;
          total_wr++;
          wr_pend = 1'b1;
          wr_idx  = mem_addr[12:2];
          wr_data = mem_wdata;
        end
      end
      if (resp_valid) begin
        n_checks++;
        if (exp_q.size() == 0 || hs_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_resp: got rdata=%h err=%b, required no response", resp_rdata, resp_err);
        end else begin
          e   = exp_q.pop_front();
          h   = hs_q.pop_front();
          lat = cyc - h;
          $display("txn %s: rdata=%h err=%b latency=%0d reads=%0d writes=%0d", e.name, resp_rdata, resp_err, lat, cur_rd, cur_wr);
          if (resp_rdata !== e.rdata || resp_err !== e.err || lat != e.lat || cur_rd != e.nrd || cur_wr != e.nwr) begin
            n_fail++;
            $display("FAIL resp_%s: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d, required rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                     e.name, resp_rdata, resp_err, lat, cur_rd, cur_wr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
          end
          last_rdata = resp_rdata;
        end
        cur_rd = 0;
        cur_wr = 0;
      end
    end
    @(posedge clk);
    if (wr_pend) dmem[wr_idx] = wr_data;
    wr_pend = 1'b0;
    cyc++;
    #1;
  endtask

  // Predict the outcome of a request from the reference memory
  task automatic push_exp(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [63:0] nm);
    exp_t        e;
    logic [10:0] idx;
    idx     = a[12:2];
    e.name  = nm;
    e.waddr = {a[31:2], 2'b00};
    e.wdata = 32'h0;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    if (model_err(we, f3, a)) begin
      e.err = 1'b1; e.lat = 1; e.nrd = 0; e.nwr = 0;
    end else if (!we) begin
      e.rdata = model_load(ref_mem[idx], f3, a[1:0]);
      e.lat = 2; e.nrd = 1; e.nwr = 0;
    end else if (f3 == 3'b010) begin
      e.wdata = wd;
      ref_mem[idx] = wd;
      e.lat = 2; e.nrd = 0; e.nwr = 1;
    end else begin
      e.wdata = model_merge(ref_mem[idx], f3, a[1:0], wd);
      ref_mem[idx] = e.wdata;
      e.lat = 3; e.nrd = 1; e.nwr = 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [63:0] nm, input bit keep, output int waited);
    bit got;
    push_exp(we, f3, a, wd, nm);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    waited     = 0;
    got        = 1'b0;
    while (!got && waited < 40) begin
      cycle();
      waited++;
      got = hs_now;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL handshake_%s: got no handshake in %0d cycles, required one", nm, waited);
    end
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      cycle();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    dmem[a[12:2]]    = w;
    ref_mem[a[12:2]] = w;
  endtask

  task automatic test_reset();
    int w;
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    req_wdata  = 32'h0;
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got ready=%b rv=%b rd=%b, required 0", req_ready, resp_valid, mem_read);
    end
    preload(32'h100, 32'h8899_AABB);
    rst_n = 1'b1;
    send(1'b0, 3'b000, 32'h101, 32'h0, "LB_first", 1'b0, w);
    n_checks++;
    if (w != 1) begin
      n_fail++;
      $display("FAIL first_handshake: got accepted after %0d cycles, required 1", w);
    end
    drain();
  endtask

  task automatic test_loads();
    int w;
    preload(32'h100, 32'h8899_AABB);
    send(1'b0, 3'b000, 32'h101, 32'h0, "LB101", 1'b0, w); drain();
    n_checks++;
    if (last_rdata !== 32'hFFFF_FFAA) begin
      n_fail++;
      $display("FAIL lb_value: got %h, required ffffffaa", last_rdata);
    end
    send(1'b0, 3'b100, 32'h103, 32'h0, "LBU103", 1'b0, w); drain();
    send(1'b0, 3'b001, 32'h102, 32'h0, "LH102", 1'b0, w); drain();
    n_checks++;
    if (last_rdata !== 32'hFFFF_8899) begin
      n_fail++;
      $display("FAIL lh_value: got %h, required ffff8899", last_rdata);
    end
    send(1'b0, 3'b101, 32'h100, 32'h0, "LHU100", 1'b0, w); drain();
    send(1'b0, 3'b000, 32'h100, 32'h0, "LB100", 1'b0, w); drain();
    send(1'b0, 3'b010, 32'h100, 32'h0, "LW100", 1'b0, w); drain();
  endtask

  task automatic test_sub_word_stores();
    int w;
    int wr0;
    wr0 = total_wr;
    send(1'b1, 3'b000, 32'h102, 32'h1234_5677, "SB102", 1'b0, w); drain();
    send(1'b1, 3'b001, 32'h100, 32'h0000_CAFE, "SH100", 1'b0, w); drain();
    n_checks++;
    if (dmem[32'h100 >> 2] !== 32'h8877_CAFE || total_wr - wr0 != 2) begin
      n_fail++;
      $display("FAIL rmw_result: got word=%h writes=%0d, required 8877cafe writes=2", dmem[32'h100 >> 2], total_wr - wr0);
    end
  endtask

  task automatic test_store_word();
    int w;
    send(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, "SW104", 1'b0, w); drain();
    n_checks++;
    if (dmem[32'h104 >> 2] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_result: got %h, required deadbeef", dmem[32'h104 >> 2]);
    end
  endtask

  task automatic test_errors();
    int w;
    int wr0;
    wr0 = total_wr;
    send(1'b0, 3'b010, 32'h102,  32'h0,  "LW102e", 1'b0, w); drain();
    send(1'b1, 3'b001, 32'h101,  32'h55, "SH101e", 1'b0, w); drain();
    send(1'b0, 3'b011, 32'h100,  32'h0,  "F3_011e", 1'b0, w); drain();
    send(1'b0, 3'b010, 32'h2000, 32'h0,  "LW2000e", 1'b0, w); drain();
    send(1'b1, 3'b100, 32'h100,  32'h77, "SB_1xxe", 1'b0, w); drain();
    send(1'b0, 3'b101, 32'h103,  32'h0,  "LHU103e", 1'b0, w); drain();
    n_checks++;
    if (total_wr != wr0 || dmem[32'h100 >> 2] !== 32'h8877_CAFE) begin
      n_fail++;
      $display("FAIL err_no_write: got writes=%0d word=%h, required 0 and 8877cafe", total_wr - wr0, dmem[32'h100 >> 2]);
    end
  endtask

  task automatic test_reset_abort();
    int w;
    int wr0;
    preload(32'h200, 32'h1122_3344);
    wr0 = total_wr;
    send(1'b1, 3'b000, 32'h201, 32'h0000_0055, "SBabort", 1'b0, w);
    cycle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_write !== 1'b0 || mem_wdata !== 32'h0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got wr=%b wdata=%h ready=%b, required 0", mem_write, mem_wdata, req_ready);
    end
    cycle();
    rst_n = 1'b1;
    exp_q.delete();
    ref_mem[32'h200 >> 2] = 32'h1122_3344;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || dmem[32'h200 >> 2] !== 32'h1122_3344 || total_wr != wr0) begin
      n_fail++;
      $display("FAIL abort_result: got ready=%b word=%h writes=%0d, required 1 11223344 0",
               req_ready, dmem[32'h200 >> 2], total_wr - wr0);
    end
    send(1'b0, 3'b010, 32'h200, 32'h0, "LWafter", 1'b0, w); drain();
  endtask

  task automatic test_back_to_back();
    int w;
    int wr0;
    wr0 = total_wr;
    preload(32'h300, 32'h0);
    send(1'b1, 3'b010, 32'h300, 32'hAAAA_5555, "b2bSW",  1'b1, w);
    send(1'b0, 3'b000, 32'h301, 32'h0,         "b2bLB",  1'b1, w);
    send(1'b1, 3'b001, 32'h302, 32'h0000_BEEF, "b2bSH",  1'b1, w);
    send(1'b0, 3'b010, 32'h300, 32'h0,         "b2bLW",  1'b0, w);
    drain();
    n_checks++;
    if (last_rdata !== 32'hBEEF_5555 || total_wr - wr0 != 2) begin
      n_fail++;
      $display("FAIL b2b_final: got rdata=%h writes=%0d, required beef5555 writes=2", last_rdata, total_wr - wr0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      dmem[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    test_reset();
    test_loads();
    test_sub_word_stores();
    test_store_word();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    for (int i = 0; i < 3; i++) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 13; number of low address bits the data memory decodes (8 KB).
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req_valid  input  1  CPU access request.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load data.
REQ-012 resp_err  output  1  misaligned, illegal-width or out-of-range access.
REQ-013 mem_read  output  1  read enable to the word memory.
REQ-014 mem_write  output  1  write enable to the word memory.
REQ-015 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-016 mem_wdata  output  32  full word to write.
REQ-017 mem_rdata  input  32  combinational read data, valid in the same cycle as mem_read.

Function
REQ-018 States: IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; on handshake, addr/wdata/we/funct3 are latched and the inputs are ignored until the next IDLE.
REQ-020 Error check at handshake: LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]=1, funct3 011/110/111, stores with funct3 1xx, or any addr[31:ADDR_W]!=0 -> go straight to RESP with resp_err=1, resp_rdata=0, no memory access.
REQ-021 Load: IDLE -> LOAD (mem_read=1, capture selected byte/half from mem_rdata) -> RESP; resp_valid 2 cycles after the handshake edge.
REQ-022 Load extraction: byte = word[8*addr[1:0] +: 8], half = word[16*addr[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
REQ-023 SW: IDLE -> WRITE (mem_write=1, mem_wdata=req_wdata) -> RESP.
REQ-024 SB/SH: IDLE -> RMW_RD (mem_read=1, register merged word = mem_rdata with the addressed lane replaced by wdata[7:0] or wdata[15:0]) -> WRITE (mem_write=1, mem_wdata=merged) -> RESP; unaddressed bytes are preserved bit-exact.
REQ-025 RESP: resp_valid=1 for exactly one cycle, then IDLE; a new request is accepted earliest the cycle after RESP.
REQ-026 mem_read SHALL be 1 only in LOAD/RMW_RD and mem_write only in WRITE; never both in the same cycle.
REQ-027 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0; resp_rdata=0 for all stores.
REQ-028 mem_addr SHALL carry the latched word address in LOAD/RMW_RD/WRITE and 0 otherwise; mem_wdata SHALL be 0 outside WRITE.

Reset
REQ-029 While rst_n=0: state=IDLE; req_ready, resp_valid, resp_err, mem_read and mem_write are 0 combinationally; resp_rdata, mem_addr, mem_wdata are 0; all latched request registers are cleared.
REQ-030 Reset asserted mid-operation SHALL abort the access; if asserted during WRITE, no write occurs at that edge, and an RMW aborted in RMW_RD leaves memory unchanged.
REQ-031 The first handshake SHALL be accepted in the first cycle with rst_n=1.

Verification
REQ-032 Word 0x100=0x8899AABB; LB 0x101 -> resp_valid 2 cycles after the handshake, resp_rdata=0xFFFFFFAA; LBU 0x103 -> 0x00000088; LH 0x102 -> 0xFFFF8899.
REQ-033 SB 0x102, wdata=0x12345677, on 0x8899AABB -> mem_write exactly once, mem_wdata=0x8877AABB, resp_valid 3 cycles after the handshake; then SH 0x100, wdata=0x0000CAFE -> memory word 0x8877CAFE.
REQ-034 SW 0x104, wdata=0xDEADBEEF -> mem_write in cycle +1 with mem_wdata=0xDEADBEEF, resp_valid in cycle +2, resp_rdata=0.
REQ-035 LW 0x102, SH 0x101, funct3=011 and LW 0x2000 -> resp_valid 1 cycle after the handshake with resp_err=1, resp_rdata=0; mem_read=mem_write=0 throughout.
REQ-036 SB issued, rst_n driven low in the WRITE cycle -> no mem_write at that edge, target word unchanged, outputs 0, req_ready=1 the cycle after rst_n returns high.
REQ-037 Back-to-back: req_valid held high with 4 queued requests -> req_ready pulses only in IDLE, each request completes exactly once in order, and mem_read/mem_write are never asserted together.
